affine_schedule_sequencer: RTL and testbench
============================================

# affine_schedule_sequencer

Cycle-accurate scheduler for the affine address generators in the memory tile. It walks a loop nest of up to NUM_DIMS dimensions whose iteration times are given by an affine schedule: starting_cycle plus the sum of per-dimension schedule offsets. At each scheduled cycle it pulses `step` to the address generator it drives. It reports completion (`done`) and late issues (`sched_err`).

## Interface
- NUM_DIMS, default 6: loop-nest depth supported.
- WIDTH, default 16: width of counters, ranges, strides and times.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clk_en  input  1  global clock enable; when low, all state holds and `step`=0.
- flush  input  1  synchronous clear, qualified by clk_en.
- start  input  1  begin a schedule; accepted in IDLE or DONE.
- dimensionality  input  4  number of active dims; dim 0 is innermost.
- ranges  input  NUM_DIMS×WIDTH  iteration count per dim.
- sched_strides  input  NUM_DIMS×WIDTH  cycle offset added per iteration of each dim.
- starting_cycle  input  WIDTH  cycle of the first iteration, relative to run start.
- step  output  1  one-cycle pulse per scheduled iteration, to the address generator.
- busy  output  1  state==RUN.
- done  output  1  state==DONE.
- sched_err  output  1  sticky; set when an iteration issued later than its scheduled cycle.
- iter_count  output  WIDTH  steps issued since start; wraps modulo 2^WIDTH.

## Operation
- States:
  - IDLE: after reset or flush.
  - RUN: schedule in progress.
  - DONE: all iterations issued.
- Transitions (all require clk_en=1):
  - IDLE/DONE + start → RUN. On entry: cycle_cnt=0, dim_cnt[*]=0, sched_loc[*]=0, iter_count=0, sched_err=0.
  - IDLE/DONE + start with dimensionality==0 → DONE. No step is issued.
  - RUN + step on the last iteration → DONE. The last iteration is the one where every active dim i has dim_cnt[i]==ranges[i]-1.
  - Any state + flush → IDLE. Clears all counters and sched_err. Flush has priority over start and over step.
  - start during RUN is ignored.
- Schedule time: sched_time = starting_cycle + Σ over active dims of sched_loc[i]. Computed combinationally, modulo 2^WIDTH.
- step = clk_en & RUN & (cycle_cnt >= sched_time), using an unsigned compare.
- On step:
  - Dim i updates if i < dimensionality and all lower dims are at ranges-1 (dim 0 always updates).
  - An updating dim at ranges[i]-1 sets dim_cnt[i]=0 and sched_loc[i]=0.
  - Otherwise an updating dim does dim_cnt[i]+=1 and sched_loc[i]+=sched_strides[i].
  - iter_count increments.
  - If cycle_cnt > sched_time, sched_err is set.
- cycle_cnt increments on every clk_en cycle in RUN and saturates at 2^WIDTH-1.
- Range compare uses ranges-1 modulo 2^WIDTH, so ranges==0 yields 2^WIDTH iterations of that dim.
- Inactive dims (i ≥ dimensionality) never change and contribute 0 to sched_time.
- Late iterations (non-monotonic strides) issue back-to-back, one per cycle, until caught up. No iteration is dropped.
- Config inputs must be stable from start until DONE; changing them mid-run is undefined.

## Timing
- Reset: state=IDLE; step=0, busy=0, done=0, sched_err=0, iter_count=0, all counters 0.
- Start latency:
  - start sampled at edge t → RUN from t; first RUN cycle has cycle_cnt=0.
  - With starting_cycle=S, the first step is asserted during the RUN cycle where cycle_cnt==S, i.e. S+1 cycles after the start edge.
- step is combinational from registered state, gated by clk_en. The driven generator samples it on the same edge that advances this block's counters.
- With sched_strides[0]=1 and starting_cycle=S, steps are contiguous.
- With sched_strides[0]=k, steps are spaced k cycles apart.
- done asserts the cycle after the final step and holds until start or flush.
- clk_en low mid-run freezes cycle_cnt and counters; the schedule resumes unshifted relative to enabled cycles.
- Asynchronous reset mid-RUN immediately returns the block to IDLE with all outputs 0.

## Test plan
- Simple 1-D run:
  - Stimulus: dimensionality=1, ranges[0]=4, sched_strides[0]=1, starting_cycle=2, start.
  - Response: step high on RUN cycles 2,3,4,5; iter_count=4; done the next cycle; sched_err=0.
- 2-D run with gaps:
  - Stimulus: dimensionality=2, ranges={3,2}, strides={2,10}, starting_cycle=0.
  - Response: steps at cycle_cnt 0,2,4,10,12,14; then DONE.
- Late schedule:
  - Stimulus: dimensionality=2, ranges={4,2}, strides={1,1}, starting_cycle=0.
  - Response: steps at cycles 0–3, then 4 back-to-back steps (scheduled at 1–4); sched_err=1; iter_count=8.
- Flush mid-run:
  - Stimulus: flush at the second step with clk_en=1.
  - Response: IDLE next cycle; busy=0, iter_count=0, no further steps; start then restarts from iteration 0.
- clk_en gating:
  - Stimulus: drop clk_en for 3 cycles mid-run.
  - Response: step=0 while low; remaining step spacing in enabled cycles unchanged.
- Degenerate inputs:
  - dimensionality=0 + start → done=1 next cycle, zero steps.
  - Reset asserted during RUN → all outputs 0 asynchronously.

Source files
------------

// File: rtl/affine_schedule_sequencer.sv
// affine_schedule_sequencer
//
// Walks a loop nest of up to NUM_DIMS dimensions and issues one `step` pulse per
// iteration at the cycle given by an affine schedule:
//   sched_time = starting_cycle + sum over active dims of sched_loc[i]
// where sched_loc[i] accumulates sched_strides[i] for each iteration of dim i.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clk_en           global enable; low freezes all state and forces step=0
//   flush            synchronous clear to IDLE (qualified by clk_en)
//   start            begin a schedule (accepted in IDLE or DONE)
//   dimensionality   number of active dims, dim 0 innermost
//   ranges           per-dim iteration counts (0 means 2^WIDTH)
//   sched_strides    per-dim cycle offset added per iteration
//   starting_cycle   cycle of the first iteration relative to run start
//   step             one-cycle pulse per scheduled iteration
//   busy / done      state is RUN / DONE
//   sched_err        sticky: an iteration issued after its scheduled cycle
//   iter_count       steps issued since start, wraps
module affine_schedule_sequencer #(
  parameter int unsigned NUM_DIMS = 6,
  parameter int unsigned WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clk_en,
  input  logic                               flush,
  input  logic                               start,
  input  logic [3:0]                         dimensionality,
  input  logic [NUM_DIMS-1:0][WIDTH-1:0]     ranges,
  input  logic [NUM_DIMS-1:0][WIDTH-1:0]     sched_strides,
  input  logic [WIDTH-1:0]                   starting_cycle,
  output logic                               step,
  output logic                               busy,
  output logic                               done,
  output logic                               sched_err,
  output logic [WIDTH-1:0]                   iter_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                          r_state;
  state_e                          w_state_d;
  logic [WIDTH-1:0]                r_cycle_cnt;
  logic [NUM_DIMS-1:0][WIDTH-1:0]  r_dim_cnt;
  logic [NUM_DIMS-1:0][WIDTH-1:0]  r_sched_loc;
  logic [WIDTH-1:0]                r_iter_count;
  logic                            r_sched_err;

  logic [NUM_DIMS-1:0]             w_active;
  logic [NUM_DIMS-1:0]             w_at_max;
  logic [NUM_DIMS-1:0]             w_upd;
  logic                            w_last;
  logic [WIDTH-1:0]                w_sched_time;
  logic                            w_start;

  // Per-dim decode: activity, wrap point and carry chain from inner dims.
  always_comb begin
    logic carry;
    carry        = 1'b1;
    w_sched_time = starting_cycle;
    w_active     = '0;
    w_at_max     = '0;
    w_upd        = '0;
    for (int i = 0; i < int'(NUM_DIMS); i++) begin
      w_active[i] = (i < int'(dimensionality));
      // ranges-1 wraps, so ranges==0 gives a full 2^WIDTH trip count
      w_at_max[i] = (r_dim_cnt[i] == ranges[i] - WIDTH'(1));
      w_upd[i]    = w_active[i] & carry;
      carry       = carry & w_at_max[i];
      if (w_active[i]) begin
        w_sched_time = w_sched_time + r_sched_loc[i];
      end
    end
    w_last = &(w_at_max | ~w_active);
  end

  assign step       = clk_en && (r_state == StRun) && (r_cycle_cnt >= w_sched_time);
  assign busy       = (r_state == StRun);
  assign done       = (r_state == StDone);
  assign sched_err  = r_sched_err;
  assign iter_count = r_iter_count;
  assign w_start    = start && !flush && (r_state != StRun);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_d = (dimensionality == 4'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (step && w_last) begin
          w_state_d = StDone;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (flush) begin
      w_state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else if (clk_en) begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt  <= '0;
      r_dim_cnt    <= '0;
      r_sched_loc  <= '0;
      r_iter_count <= '0;
      r_sched_err  <= 1'b0;
    end else if (clk_en) begin
      if (flush || w_start) begin
        r_cycle_cnt  <= '0;
        r_dim_cnt    <= '0;
        r_sched_loc  <= '0;
        r_iter_count <= '0;
        r_sched_err  <= 1'b0;
      end else if (r_state == StRun) begin
        if (r_cycle_cnt != '1) begin
          r_cycle_cnt <= r_cycle_cnt + WIDTH'(1);
        end
        if (step) begin
          r_iter_count <= r_iter_count + WIDTH'(1);
          if (r_cycle_cnt > w_sched_time) begin
            r_sched_err <= 1'b1;
          end
          for (int i = 0; i < int'(NUM_DIMS); i++) begin
            if (w_upd[i]) begin
              if (w_at_max[i]) begin
                r_dim_cnt[i]   <= '0;
                r_sched_loc[i] <= '0;
              end else begin
                r_dim_cnt[i]   <= r_dim_cnt[i] + WIDTH'(1);
                r_sched_loc[i] <= r_sched_loc[i] + sched_strides[i];
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_affine_schedule_sequencer.sv
// Directed bench for affine_schedule_sequencer. Step positions are recorded as a
// bitmap indexed by enabled RUN cycle (cycle_cnt) and compared to hand-built maps.
module tb_affine_schedule_sequencer;

  localparam int unsigned NUM_DIMS = 6;
  localparam int unsigned WIDTH    = 16;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic                           clk_en;
  logic                           flush;
  logic                           start;
  logic [3:0]                     dimensionality;
  logic [NUM_DIMS-1:0][WIDTH-1:0] ranges;
  logic [NUM_DIMS-1:0][WIDTH-1:0] sched_strides;
  logic [WIDTH-1:0]               starting_cycle;
  logic                           step;
  logic                           busy;
  logic                           done;
  logic                           sched_err;
  logic [WIDTH-1:0]               iter_count;

  int checks   = 0;
  int failures = 0;

  affine_schedule_sequencer #(
    .NUM_DIMS (NUM_DIMS),
    .WIDTH    (WIDTH)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .flush          (flush),
    .start          (start),
    .dimensionality (dimensionality),
    .ranges         (ranges),
    .sched_strides  (sched_strides),
    .starting_cycle (starting_cycle),
    .step           (step),
    .busy           (busy),
    .done           (done),
    .sched_err      (sched_err),
    .iter_count     (iter_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic configure(input logic [3:0] dims, input logic [WIDTH-1:0] r0,
                           input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] s0,
                           input logic [WIDTH-1:0] s1, input logic [WIDTH-1:0] sc);
    dimensionality   = dims;
    ranges           = '0;
    sched_strides    = '0;
    ranges[0]        = r0;
    ranges[1]        = r1;
    sched_strides[0] = s0;
    sched_strides[1] = s1;
    starting_cycle   = sc;
  endtask

  // Start edge is the next posedge; returns just after it.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Samples each cycle after the start edge until done. clk_en is dropped for
  // gate_len cycles beginning at raw cycle gate_at. done_k is the enabled-cycle
  // index at which done is first seen (99 if the budget expires).
  task automatic collect(input int gate_at, input int gate_len, input int budget,
                         output logic [63:0] map, output int done_k);
    int k;
    k      = 0;
    map    = '0;
    done_k = 99;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      clk_en = !(n >= gate_at && n < gate_at + gate_len);
      #1;
      if (done) begin
        done_k = k;
        break;
      end
      if (clk_en) begin
        if (step && k < 64) map[k] = 1'b1;
        k++;
      end else begin
        check("gated_step", 64'(step), 64'd0);
      end
    end
    clk_en = 1'b1;
  endtask

  logic [63:0] map;
  int          done_k;

  initial begin
    rst_n  = 1'b0;
    clk_en = 1'b1;
    flush  = 1'b0;
    start  = 1'b0;
    configure(4'd0, '0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_outputs", {59'd0, step, busy, done, sched_err},
          64'd0);
    check("rst_iter", 64'(iter_count), 64'd0);

    // 1-D: steps at 2..5, done at 6
    configure(4'd1, 16'd4, 16'd0, 16'd1, 16'd0, 16'd2);
    do_start();
    collect(1000, 0, 40, map, done_k);
    check("1d_map", map, 64'h3C);
    check("1d_done_k", 64'(done_k), 64'd6);
    check("1d_iter", 64'(iter_count), 64'd4);
    check("1d_err", 64'(sched_err), 64'd0);
    @(negedge clk);
    check("1d_done_hold", {62'd0, done, busy}, 64'd2);

    // 2-D with gaps: 0,2,4,10,12,14
    configure(4'd2, 16'd3, 16'd2, 16'd2, 16'd10, 16'd0);
    do_start();
    collect(1000, 0, 60, map, done_k);
    check("2d_map", map, 64'h5415);
    check("2d_done_k", 64'(done_k), 64'd15);
    check("2d_iter", 64'(iter_count), 64'd6);
    check("2d_err", 64'(sched_err), 64'd0);

    // Late schedule: 8 contiguous steps, error set
    configure(4'd2, 16'd4, 16'd2, 16'd1, 16'd1, 16'd0);
    do_start();
    collect(1000, 0, 60, map, done_k);
    check("late_map", map, 64'hFF);
    check("late_done_k", 64'(done_k), 64'd8);
    check("late_iter", 64'(iter_count), 64'd8);
    check("late_err", 64'(sched_err), 64'd1);

    // clk_en gating: stride 3, S=1 -> steps at enabled cycles 1,4,7
    configure(4'd1, 16'd3, 16'd0, 16'd3, 16'd0, 16'd1);
    do_start();
    collect(3, 3, 60, map, done_k);
    check("gate_map", map, 64'h92);
    check("gate_done_k", 64'(done_k), 64'd8);
    check("gate_iter", 64'(iter_count), 64'd3);

    // Flush on the second step (cycle 3), then restart
    configure(4'd1, 16'd4, 16'd0, 16'd1, 16'd0, 16'd2);
    do_start();
    repeat (4) @(negedge clk);
    #1;
    check("flush_pre_step", 64'(step), 64'd1);
    check("flush_pre_iter", 64'(iter_count), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_state", {61'd0, step, busy, done}, 64'd0);
    check("flush_iter", 64'(iter_count), 64'd0);
    map = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (step) map[i] = 1'b1;
    end
    check("flush_no_step", map, 64'd0);
    do_start();
    collect(1000, 0, 40, map, done_k);
    check("flush_restart_map", map, 64'h3C);
    check("flush_restart_iter", 64'(iter_count), 64'd4);

    // dimensionality 0: DONE immediately, no steps
    configure(4'd0, 16'd4, 16'd0, 16'd1, 16'd0, 16'd0);
    do_start();
    collect(1000, 0, 20, map, done_k);
    check("dim0_map", map, 64'd0);
    check("dim0_done_k", 64'(done_k), 64'd0);
    check("dim0_iter", 64'(iter_count), 64'd0);

    // Async reset during RUN after an error has been flagged
    configure(4'd2, 16'd4, 16'd2, 16'd1, 16'd1, 16'd0);
    do_start();
    repeat (7) @(negedge clk);
    #1;
    check("arst_pre", {61'd0, busy, sched_err, step}, 64'd7);
    check("arst_pre_iter", 64'(iter_count), 64'd6);
    #1 rst_n = 1'b0;
    #1;
    check("arst_outputs", {60'd0, step, busy, done, sched_err}, 64'd0);
    check("arst_iter", 64'(iter_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
